mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter sharing the single off-chip memory port between the instruction-cache and data-cache miss/write-back engines of the pipelined MIPS core. It accepts one line-sized transaction at a time and grants it by round-robin. It drives the shared memory handshake and returns a one-cycle ready pulse, with the fetched line, to the winning cache. A watchdog flags a memory that never responds.

## Interface
- ADDR_W, 28, line-address width (byte address [31:4])
- DATA_W, 128, line width in bits
- TIMEOUT, 1023, max cycles in a grant state before timeout_err sets; fits in 10 bits
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ic_read  in  1  I-cache line-read request, held until ic_ready
- ic_addr  in  ADDR_W  I-cache line address
- ic_rdata  out  DATA_W  returned line (shared capture register)
- ic_ready  out  1  one-cycle completion pulse to I-cache
- dc_read  in  1  D-cache line-read request, held until dc_ready
- dc_write  in  1  D-cache write-back request, held until dc_ready
- dc_addr  in  ADDR_W  D-cache line address
- dc_wdata  in  DATA_W  write-back line
- dc_rdata  out  DATA_W  returned line (same register as ic_rdata)
- dc_ready  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe, level, held until mem_ready
- mem_write  out  1  memory write strobe, level, held until mem_ready
- mem_addr  out  ADDR_W  memory line address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, one cycle
- timeout_err  out  1  sticky watchdog flag

## Operation
- States: IDLE, GNT_I, GNT_D, DONE. Plus a last_gnt bit (0=I, 1=D) and a 10-bit watchdog counter.
- Reset: state IDLE, last_gnt=0, and the counter at 0. All outputs are 0: mem_read, mem_write, mem_addr, mem_wdata, ic_ready, dc_ready, rdata register, timeout_err.
- IDLE, with req_i=ic_read and req_d=dc_read|dc_write:
  - Only req_i: go to GNT_I.
  - Only req_d: go to GNT_D.
  - Both: grant the side not equal to last_gnt. After reset, a tie goes to D.
  - Neither: stay.
- On entering GNT_I: register mem_read=1 and mem_addr=ic_addr, and set last_gnt=0.
- On entering GNT_D: register mem_addr=dc_addr and set last_gnt=1.
  - If dc_write: mem_write=1 and mem_wdata=dc_wdata. Write wins if dc_read and dc_write are both high.
  - Else: mem_read=1.
- Addr, wdata and direction are latched at grant. Later changes on the request inputs are ignored until DONE.
- GNT_x with mem_ready=1:
  - Clear mem_read and mem_write.
  - On a read, capture mem_rdata into the rdata register. On a write, the register is unchanged.
  - Go to DONE and assert the matching ready for exactly the DONE cycle.
- DONE: go to IDLE unconditionally. Requests are not sampled in DONE, so a request still high in DONE is not re-granted.
- mem_ready while in IDLE or DONE is ignored.
- Watchdog:
  - The counter clears on entry to GNT_x and increments each GNT_x cycle without mem_ready.
  - When the count reaches TIMEOUT, timeout_err sets and stays set until rst.
  - The transaction keeps waiting; there is no abort.
- Reset mid-transaction returns everything to reset values. A late mem_ready is then ignored.

## Timing
- Request high in IDLE cycle t: mem_read or mem_write is high from t+1.
- mem_ready high in cycle r: the strobe is low from r+1, and ready plus valid rdata appear in cycle r+1.
- Minimum turnaround: request in t, mem_ready in t+1, ready in t+2, IDLE in t+3, next grant strobe in t+4.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rdata holds its value until the next read completion.

## Test plan
- Reset behaviour: assert rst for 2 cycles during GNT_D with mem_write=1. Required: all outputs are 0 the next cycle, and a later mem_ready produces no ready pulse.
- Single I read: ic_read with ic_addr=0x0000123, memory responds 3 cycles after the strobe with 128'hDEADBEEF_...01. Required:
  - mem_read=1 and mem_addr=0x0000123 from t+1.
  - ic_ready is high for exactly 1 cycle, ic_rdata equals the data, and dc_ready stays 0.
- Tie after reset: ic_read and dc_read rise in the same cycle. Required: D is served first, then I, then a further tie is served D (round-robin).
- Write-back then refill: dc_write with dc_addr=0x00000A0, then dc_read with dc_addr=0x00000B0. Required:
  - mem_write=1 with mem_wdata=dc_wdata.
  - dc_ready pulses and rdata is unchanged.
  - A separate mem_read to 0x00000B0 follows.
- Stale request: hold ic_read high through DONE for 1 cycle after ic_ready. Required: a second I transaction starts only because the request is still high in IDLE, with no grant taken in DONE.
- Watchdog: a D grant with memory never responding. Required: timeout_err=1 at TIMEOUT cycles after the grant and still 1 after mem_ready finally arrives; the transaction then completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter that shares one line-wide memory port
// between the I-cache and D-cache engines. It serves one transaction at a
// time, returns a one-cycle ready pulse with the fetched line, and raises a
// sticky watchdog flag when memory never answers.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_e;

  localparam logic [9:0] TIMEOUT_C = 10'(TIMEOUT);

  state_e              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;   // 0 = I won last, 1 = D won last
  logic [9:0]          wd_cnt_q, wd_cnt_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ic_ready_q, ic_ready_d;
  logic                dc_ready_q, dc_ready_d;
  logic                timeout_err_q, timeout_err_d;

  logic req_i, req_d, pick_d;

  assign req_i  = ic_read;
  assign req_d  = dc_read | dc_write;
  // D wins when it is the only requester, or on a tie when I won last time.
  assign pick_d = req_d & (~req_i | ~last_gnt_q);

  // Next-state and next-output computation for the grant FSM and watchdog.
  always_comb begin
    // NOTE: every _d starts from its _q (or a pulse default) so no branch
    // leaves a signal unassigned and no latch is inferred.
    state_d       = state_q;
    last_gnt_d    = last_gnt_q;
    wd_cnt_d      = wd_cnt_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    timeout_err_d = timeout_err_q;
    ic_ready_d    = 1'b0;
    dc_ready_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i | req_d) begin
          wd_cnt_d = '0;
          if (pick_d) begin
            state_d    = GNT_D;
            last_gnt_d = 1'b1;
            mem_addr_d = dc_addr;
            // A write-back takes priority over a refill from the same cache.
            if (dc_write) begin
              mem_write_d = 1'b1;
              mem_wdata_d = dc_wdata;
            end else begin
              mem_read_d  = 1'b1;
            end
          end else begin
            state_d    = GNT_I;
            last_gnt_d = 1'b0;
            mem_addr_d = ic_addr;
            mem_read_d = 1'b1;
          end
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) rdata_d = mem_rdata;
          ic_ready_d  = (state_q == GNT_I);
          dc_ready_d  = (state_q == GNT_D);
          state_d     = DONE;
        end else begin
          // Saturate so a hung memory cannot wrap the counter.
          if (wd_cnt_q != TIMEOUT_C) wd_cnt_d = wd_cnt_q + 10'd1;
          if (wd_cnt_q >= TIMEOUT_C - 10'd1) timeout_err_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;   // requests deliberately not sampled here
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state_q       <= IDLE;
      last_gnt_q    <= 1'b0;
      wd_cnt_q      <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      ic_ready_q    <= 1'b0;
      dc_ready_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_gnt_q    <= last_gnt_d;
      wd_cnt_q      <= wd_cnt_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      ic_ready_q    <= ic_ready_d;
      dc_ready_q    <= dc_ready_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign ic_rdata    = rdata_q;
  assign dc_rdata    = rdata_q;
  assign ic_ready    = ic_ready_q;
  assign dc_ready    = dc_ready_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transactions, a transaction-level
// reference model compared every cycle, plus literal expectations.
module tb_mem_arbiter;
  localparam int ADDR_W  = 28;
  localparam int DATA_W  = 128;
  localparam int TIMEOUT = 1023;

  localparam logic [127:0] DATA1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] DATA3 = 128'h0BADF00D_11112222_33334444_55556666;
  localparam logic [127:0] DATA4 = 128'hCAFEBABE_00000000_00000000_00000004;
  localparam logic [127:0] JUNK  = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
  localparam logic [127:0] WBUF  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ic_read = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_ready;
  logic              dc_read = 1'b0;
  logic              dc_write = 1'b0;
  logic [ADDR_W-1:0] dc_addr = '0;
  logic [DATA_W-1:0] dc_wdata = '0;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
  logic              timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit                m_busy, m_done, m_side_d, m_wr, m_last, m_err, m_want_d;
  int                m_wait;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_side_d = 0; m_wr = 0; m_last = 0; m_err = 0;
      m_wait = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (mem_ready) begin
        m_busy = 0;
        m_done = 1;
        if (!m_wr) m_rdata = mem_rdata;
      end else begin
        m_wait++;
        if (m_wait >= TIMEOUT) m_err = 1;
      end
    end else if (ic_read || dc_read || dc_write) begin
      m_want_d = (dc_read || dc_write) && (!ic_read || !m_last);
      m_busy   = 1;
      m_wait   = 0;
      m_side_d = m_want_d;
      m_last   = m_want_d;
      m_wr     = m_want_d && dc_write;
      m_addr   = m_want_d ? dc_addr : ic_addr;
      if (m_wr) m_wdata = dc_wdata;
    end
    #2;
    check("model mem_read",    mem_read,    m_busy && !m_wr);
    check("model mem_write",   mem_write,   m_busy && m_wr);
    check("model ic_ready",    ic_ready,    m_done && !m_side_d);
    check("model dc_ready",    dc_ready,    m_done && m_side_d);
    check("model ic_rdata",    ic_rdata,    m_rdata);
    check("model dc_rdata",    dc_rdata,    m_rdata);
    check("model timeout_err", timeout_err, m_err);
    if (m_busy) check("model mem_addr", mem_addr, m_addr);
    if (m_busy && m_wr) check("model mem_wdata", mem_wdata, m_wdata);
  end

  // ---------------- stimulus helpers (negedge timeline) ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_strobe(input string name);
    int i = 0;
    while (!(mem_read || mem_write) && i < 20) begin
      tick();
      i++;
    end
    check({name, " strobe seen"}, mem_read | mem_write, 1'b1);
  endtask

  // Wait 'extra' cycles, then drive a one-cycle mem_ready with data.
  task automatic respond(input logic [127:0] data, input int extra);
    repeat (extra) tick();
    mem_rdata = data;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  // Count ready pulses over 4 cycles, dropping a request once it is answered.
  task automatic collect(output int ic_n, output int dc_n);
    ic_n = 0;
    dc_n = 0;
    for (int i = 0; i < 4; i++) begin
      if (ic_ready) begin ic_n++; ic_read = 1'b0; end
      if (dc_ready) begin dc_n++; dc_read = 1'b0; dc_write = 1'b0; end
      tick();
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " mem_read"},    mem_read,    1'b0);
    check({name, " mem_write"},   mem_write,   1'b0);
    check({name, " mem_addr"},    mem_addr,    '0);
    check({name, " mem_wdata"},   mem_wdata,   '0);
    check({name, " ic_ready"},    ic_ready,    1'b0);
    check({name, " dc_ready"},    dc_ready,    1'b0);
    check({name, " rdata"},       ic_rdata,    '0);
    check({name, " timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL global time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    int ic_n, dc_n;

    // A: reset state
    repeat (2) tick();
    rst = 1'b0;
    check_all_zero("reset");

    // B: tie after reset goes to D, then I, then the next tie goes to D
    ic_read = 1; ic_addr = 28'h0000111;
    dc_read = 1; dc_addr = 28'h0000222;
    tick();
    check("tie1 mem_addr is D", mem_addr, 28'h0000222);
    respond(128'h1, 0);
    collect(ic_n, dc_n);
    check("tie1 dc pulses", 32'(dc_n), 32'd1);
    check("tie1 ic pulses", 32'(ic_n), 32'd0);
    wait_strobe("tie1 I");
    check("tie1 then I mem_addr", mem_addr, 28'h0000111);
    respond(128'h2, 0);
    collect(ic_n, dc_n);
    check("tie1 I pulses", 32'(ic_n), 32'd1);
    ic_read = 1; ic_addr = 28'h0000444;
    dc_read = 1; dc_addr = 28'h0000333;
    tick();
    check("tie2 mem_addr is D", mem_addr, 28'h0000333);
    respond(128'h3, 1);
    collect(ic_n, dc_n);
    check("tie2 dc pulses", 32'(dc_n), 32'd1);
    wait_strobe("tie2 I");
    check("tie2 then I mem_addr", mem_addr, 28'h0000444);
    respond(128'h4, 0);
    collect(ic_n, dc_n);

    // C: single I read, memory answers a few cycles after the strobe
    ic_read = 1; ic_addr = 28'h0000123;
    tick();
    check("iread mem_read t+1", mem_read, 1'b1);
    check("iread mem_addr", mem_addr, 28'h0000123);
    respond(DATA1, 3);
    collect(ic_n, dc_n);
    check("iread ic pulses", 32'(ic_n), 32'd1);
    check("iread dc pulses", 32'(dc_n), 32'd0);
    check("iread ic_rdata", ic_rdata, DATA1);

    // D: write-back then refill
    dc_write = 1; dc_addr = 28'h00000A0; dc_wdata = WBUF;
    tick();
    check("wb mem_write", mem_write, 1'b1);
    check("wb mem_read", mem_read, 1'b0);
    check("wb mem_addr", mem_addr, 28'h00000A0);
    check("wb mem_wdata", mem_wdata, WBUF);
    respond(JUNK, 1);
    collect(ic_n, dc_n);
    check("wb dc pulses", 32'(dc_n), 32'd1);
    check("wb rdata unchanged", dc_rdata, DATA1);
    dc_read = 1; dc_addr = 28'h00000B0;
    tick();
    check("refill mem_read", mem_read, 1'b1);
    check("refill mem_write", mem_write, 1'b0);
    check("refill mem_addr", mem_addr, 28'h00000B0);
    respond(DATA3, 0);
    collect(ic_n, dc_n);
    check("refill dc pulses", 32'(dc_n), 32'd1);
    check("refill dc_rdata", dc_rdata, DATA3);

    // E: stale request held one cycle past DONE is granted from IDLE only
    ic_read = 1; ic_addr = 28'h0000140;
    wait_strobe("stale first");
    respond(128'h55, 1);
    check("stale ic_ready", ic_ready, 1'b1);
    tick();
    check("stale no grant from DONE", mem_read, 1'b0);
    tick();
    check("stale regrant from IDLE", mem_read, 1'b1);
    ic_read = 0;
    respond(128'h66, 0);
    collect(ic_n, dc_n);
    check("stale second ic pulses", 32'(ic_n), 32'd1);

    // F: watchdog
    dc_read = 1; dc_addr = 28'h00000D0;
    tick();
    check("wdog grant mem_read", mem_read, 1'b1);
    check("wdog err at grant", timeout_err, 1'b0);
    repeat (TIMEOUT - 1) tick();
    check("wdog err before limit", timeout_err, 1'b0);
    tick();
    check("wdog err at limit", timeout_err, 1'b1);
    respond(DATA4, 2);
    collect(ic_n, dc_n);
    check("wdog dc pulses", 32'(dc_n), 32'd1);
    check("wdog err sticky", timeout_err, 1'b1);
    check("wdog dc_rdata", dc_rdata, DATA4);

    // G: reset during a D write, then a late mem_ready is ignored
    dc_write = 1; dc_addr = 28'h00000C0; dc_wdata = WBUF;
    tick();
    check("rstmid mem_write", mem_write, 1'b1);
    tick();
    rst = 1;
    repeat (2) tick();
    rst = 0; dc_write = 0;
    check_all_zero("rstmid");
    tick();
    respond(JUNK, 0);
    collect(ic_n, dc_n);
    check("rstmid late ic pulses", 32'(ic_n), 32'd0);
    check("rstmid late dc pulses", 32'(dc_n), 32'd0);
    check("rstmid rdata stays 0", ic_rdata, '0);

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
